// File: rtl/probe_access_responder.sv
// Indexed probe-register bank with an INFO word and a null-terminated SCAN cursor,
// served over valid/ready request/response channels. Optional hardware write port: PROBE_HW_PORT_EN.
module probe_access_responder #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef PROBE_HW_PORT_EN
  input  logic              hw_we,
  input  logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] hw_idx,
  input  logic [DATA_W-1:0] hw_wdata,
`endif
  output logic              rsp_err
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CW = $clog2(NUM_REGS + 1);

  localparam logic [ADDR_W-1:0] SCAN_ADDR  = '1;
  localparam logic [ADDR_W-1:0] INFO_ADDR  = SCAN_ADDR - ADDR_W'(1);
  localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [DATA_W-1:0] NUM_REGS_D = DATA_W'(NUM_REGS);
  localparam logic [CW-1:0]     NUM_REGS_C = CW'(NUM_REGS);
  localparam logic [DATA_W-1:0] INFO_WORD  = {(DATA_W/2)'(NUM_REGS), (DATA_W/2)'(DATA_W)};

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state, state_d;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CW-1:0]     cursor, cursor_d;
  logic              accept;
  logic              is_reg;
  logic [IW-1:0]     reg_idx;
  logic              bus_we;
  logic [DATA_W-1:0] rdata_d;
  logic              err_d;
  logic              hw_hit;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign is_reg    = {1'b0, req_addr} < NUM_REGS_A;
  assign reg_idx   = req_addr[IW-1:0];

`ifdef PROBE_HW_PORT_EN
  assign hw_hit = hw_we && ({1'b0, hw_idx} < (IW + 1)'(NUM_REGS));
`else
  assign hw_hit = 1'b0;
`endif

  // Request decode: response payload, bus write enable and next cursor.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rdata_d  = '0;
    err_d    = 1'b0;
    bus_we   = 1'b0;
    cursor_d = cursor;
    if (req_write) begin
      if (is_reg) begin
        bus_we = 1'b1;
      end else if (req_addr == SCAN_ADDR) begin
        cursor_d = (req_wdata >= NUM_REGS_D) ? NUM_REGS_C : req_wdata[CW-1:0];
      end else begin
        err_d = 1'b1;
      end
    end else begin
      if (is_reg) begin
        rdata_d = regs[reg_idx];
      end else if (req_addr == INFO_ADDR) begin
        rdata_d = INFO_WORD;
      end else if (req_addr == SCAN_ADDR) begin
        if (cursor == NUM_REGS_C) begin
          err_d = 1'b1;
        end else begin
          rdata_d  = regs[cursor[IW-1:0]];
          cursor_d = cursor + CW'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end
`ifdef PROBE_HW_PORT_EN
    // A same-edge hardware write to the same register wins; the bus write is refused.
    if (bus_we && hw_hit && (hw_idx == reg_idx)) begin
      bus_we = 1'b0;
      err_d  = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid)  state_d = RESP;
      RESP:    if (rsp_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cursor    <= '0;
      // NOTE: the bank is flops with a defined reset value, so it is reset like any other state.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      state <= state_d;
      if (accept) begin
        rsp_rdata <= rdata_d;
        rsp_err   <= err_d;
        cursor    <= cursor_d;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (accept && bus_we && (reg_idx == IW'(i))) regs[i] <= req_wdata;
`ifdef PROBE_HW_PORT_EN
        if (hw_hit && (hw_idx == IW'(i))) regs[i] <= hw_wdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_probe_access_responder.sv
// Randomized self-checking bench for probe_access_responder against a map-level model.
// Exercises the hardware write port when PROBE_HW_PORT_EN is defined.
module tb_probe_access_responder;

  localparam int NREG = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef PROBE_HW_PORT_EN
  logic        hw_we;
  logic [3:0]  hw_idx;
  logic [31:0] hw_wdata;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [NREG];
  int          cur;

  always #5 clk = ~clk;

  probe_access_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef PROBE_HW_PORT_EN
    .hw_we(hw_we), .hw_idx(hw_idx), .hw_wdata(hw_wdata),
`endif
    .rsp_err(rsp_err)
  );

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) mem[i] = 32'd0;
    cur = 0;
  endtask

  // Map-level behaviour: what the initiator should see for one access.
  task automatic model_access(input logic wr, input int addr, input logic [31:0] wd,
                              output logic [31:0] ed, output logic ee);
    ed = 32'd0;
    ee = 1'b0;
    if (addr < NREG) begin
      if (wr) mem[addr] = wd;
      else    ed = mem[addr];
    end else if (addr == 254) begin
      if (wr) ee = 1'b1;
      else    ed = (NREG << 16) | 32;
    end else if (addr == 255) begin
      if (wr) begin
        cur = (wd > NREG) ? NREG : int'(wd);
      end else if (cur == NREG) begin
        ee = 1'b1;
      end else begin
        ed  = mem[cur];
        cur = cur + 1;
      end
    end else begin
      ee = 1'b1;
    end
  endtask

  task automatic finish_rsp(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_handshake: rsp_valid=%b req_ready=%b, want 0/1", tag, rsp_valid, req_ready);
    end
  endtask

  task automatic txn(input logic wr, input int addr, input logic [31:0] wd, input int hold,
                     input string tag);
    logic [31:0] ed;
    logic        ee;
    model_access(wr, addr, wd, ed, ee);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = 8'(addr); req_wdata = wd; rsp_ready = 1'b0;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_idle: req_ready=%b, want 1", tag, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s latency: rsp_valid=%b req_ready=%b, want 1/0", tag, rsp_valid, req_ready);
    end
    n_checks++;
    if (rsp_rdata !== ed || rsp_err !== ee) begin
      n_fail++;
      $display("FAIL %s payload: rdata=%h err=%b, want %h/%b", tag, rsp_rdata, rsp_err, ed, ee);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== ed || rsp_err !== ee) begin
        n_fail++;
        $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h err=%b, want 1/0/%h/%b",
                 tag, k, rsp_valid, req_ready, rsp_rdata, rsp_err, ed, ee);
      end
    end
    finish_rsp(tag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
`ifdef PROBE_HW_PORT_EN
    hw_we = 1'b0; hw_idx = '0; hw_wdata = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b rdata=%h err=%b, want 0/1/0/0",
               rsp_valid, req_ready, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 3, 32'd0, 1, "reset_read_reg3");
  endtask

  task automatic test_basic_rw();
    txn(1'b1, 5, 32'hDEADBEEF, 0, "write_reg5");
    txn(1'b0, 5, 32'd0, 4, "read_reg5_stall");
  endtask

  task automatic test_info_unmapped();
    txn(1'b0, 254, 32'd0, 0, "info_read");
    txn(1'b1, 254, 32'h12345678, 0, "info_write");
    txn(1'b0, 254, 32'd0, 0, "info_reread");
    txn(1'b0, 8'h40, 32'd0, 0, "unmapped_read");
    txn(1'b1, 8'h40, 32'h1, 0, "unmapped_write");
  endtask

  task automatic test_scan();
    for (int i = 0; i < NREG; i++) txn(1'b1, i, 32'(i + 100), 0, "scan_fill");
    txn(1'b1, 255, 32'd14, 0, "scan_set14");
    txn(1'b0, 255, 32'd0, 0, "scan_rd14");
    txn(1'b0, 255, 32'd0, 0, "scan_rd15");
    txn(1'b0, 255, 32'd0, 0, "scan_null");
    txn(1'b0, 255, 32'd0, 0, "scan_null_again");
    txn(1'b1, 255, 32'hFF, 0, "scan_sat");
    txn(1'b0, 255, 32'd0, 0, "scan_sat_null");
    txn(1'b1, 255, 32'd16, 0, "scan_set16");
    txn(1'b0, 255, 32'd0, 0, "scan_16_null");
    txn(1'b1, 255, 32'd0, 0, "scan_set0");
    txn(1'b0, 255, 32'd0, 0, "scan_rd0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int          kind;
      int          addr;
      logic        wr;
      logic [31:0] wd;
      kind = int'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      case (kind)
        0:       addr = int'($urandom_range(0, NREG - 1));
        1:       addr = 254;
        2:       begin addr = 255; wd = 32'($urandom_range(0, 20)); end
        default: addr = int'($urandom_range(NREG, 253));
      endcase
      txn(wr, addr, wd, int'($urandom_range(0, 2)), "random");
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd2; req_wdata = 32'd7; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_in_resp: rsp_valid=%b, want 1", rsp_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_async: valid=%b rdata=%h err=%b ready=%b, want 0/0/0/1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 2, 32'd0, 0, "arst_reg2");
    txn(1'b0, 255, 32'd0, 0, "arst_cursor");
  endtask

`ifdef PROBE_HW_PORT_EN
  task automatic test_hw_collision();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd1; req_wdata = 32'hB; rsp_ready = 1'b0;
    hw_we = 1'b1; hw_idx = 4'd1; hw_wdata = 32'hA;
    @(posedge clk); #1;
    req_valid = 1'b0; hw_we = 1'b0;
    mem[1] = 32'hA;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL hw_collide_write: valid=%b err=%b rdata=%h, want 1/1/0", rsp_valid, rsp_err, rsp_rdata);
    end
    finish_rsp("hw_collide_write");
    txn(1'b0, 1, 32'd0, 0, "hw_collide_reread");
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'd1;
    hw_we = 1'b1; hw_idx = 4'd1; hw_wdata = 32'hC;
    @(posedge clk); #1;
    req_valid = 1'b0; hw_we = 1'b0;
    n_checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'hA) begin
      n_fail++;
      $display("FAIL hw_collide_read: err=%b rdata=%h, want 0/0000000a", rsp_err, rsp_rdata);
    end
    mem[1] = 32'hC;
    finish_rsp("hw_collide_read");
    txn(1'b0, 1, 32'd0, 0, "hw_after_read");
  endtask
`endif

  initial begin
    test_reset();
    test_basic_rw();
    test_info_unmapped();
    test_scan();
    test_random();
    test_async_reset();
`ifdef PROBE_HW_PORT_EN
    test_hw_collision();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
